// File: rtl/rw_recovery_request_arbiter_pkg.sv
// Shared pipeline types for the RW-stage recovery request arbiter.
// Contents:
//   RefetchType        - encoded refetch kind sent along with a recovery
//   RwRecoveryArbState - arbiter FSM states
//   ActiveListAge      - distance of an ActiveList entry from the head
package rw_recovery_request_arbiter_pkg;

  localparam int AL_INDEX_W = 6;
  localparam int REFETCH_W  = 3;

  typedef enum logic [REFETCH_W-1:0] {
    REFETCH_TYPE_THIS_PC                = 3'd0,
    REFETCH_TYPE_NEXT_PC                = 3'd1,
    REFETCH_TYPE_BRANCH_TARGET          = 3'd2,
    REFETCH_TYPE_NEXT_PC_TO_CSR_TARGET  = 3'd3,
    REFETCH_TYPE_THIS_PC_TO_CSR_TARGET  = 3'd4
  } RefetchType;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2
  } RwRecoveryArbState;

  // Modular subtraction keeps ordering correct across head wrap-around.
  function automatic logic [AL_INDEX_W-1:0] ActiveListAge(
    input logic [AL_INDEX_W-1:0] ptr,
    input logic [AL_INDEX_W-1:0] head
  );
    return ptr - head;
  endfunction

endpackage

// File: rtl/rw_recovery_request_arbiter_if.sv
// Bundle between the RW-stage lanes / recovery manager and the arbiter.
// master: drives lane requests, head pointer and manager status.
// slave : the arbiter; drives the issued exception request and pending.
interface rw_recovery_request_arbiter_if #(
  parameter int LANES          = 3,
  parameter int AL_INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH     = 32,
  parameter int REFETCH_WIDTH  = 3
);
  logic [LANES-1:0]                     req_valid;
  logic [LANES-1:0][AL_INDEX_WIDTH-1:0] req_ptr;
  logic [LANES-1:0][ADDR_WIDTH-1:0]     req_pc;
  logic [LANES-1:0][REFETCH_WIDTH-1:0]  req_refetch;
  logic [AL_INDEX_WIDTH-1:0]            al_head_ptr;
  logic                                 unable_to_start_recovery;
  logic                                 cm_exception_detected;
  logic                                 exception_detected_rw;
  logic [AL_INDEX_WIDTH-1:0]            rw_exception_ptr;
  logic [ADDR_WIDTH-1:0]                recovered_pc_rw;
  logic [REFETCH_WIDTH-1:0]             refetch_type_rw;
  logic                                 pending;

  modport master (
    output req_valid, req_ptr, req_pc, req_refetch, al_head_ptr,
           unable_to_start_recovery, cm_exception_detected,
    input  exception_detected_rw, rw_exception_ptr, recovered_pc_rw,
           refetch_type_rw, pending
  );

  modport slave (
    input  req_valid, req_ptr, req_pc, req_refetch, al_head_ptr,
           unable_to_start_recovery, cm_exception_detected,
    output exception_detected_rw, rw_exception_ptr, recovered_pc_rw,
           refetch_type_rw, pending
  );
endinterface

// File: rtl/rw_recovery_age_select.sv
// Combinational oldest-of-LANES selector.
// Inputs : valid/ptr/pc/refetch per lane, head (age origin).
// Outputs: sel_valid, sel_lane, sel_ptr, sel_pc, sel_refetch of the oldest
//          valid lane; equal ages resolve to the lowest lane index.
module rw_recovery_age_select
  import rw_recovery_request_arbiter_pkg::*;
#(
  parameter int LANES          = 3,
  parameter int AL_INDEX_WIDTH = AL_INDEX_W,
  parameter int ADDR_WIDTH     = 32,
  parameter int REFETCH_WIDTH  = REFETCH_W,
  parameter int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0]                     valid,
  input  logic [LANES-1:0][AL_INDEX_WIDTH-1:0] ptr,
  input  logic [LANES-1:0][ADDR_WIDTH-1:0]     pc,
  input  logic [LANES-1:0][REFETCH_WIDTH-1:0]  refetch,
  input  logic [AL_INDEX_WIDTH-1:0]            head,
  output logic                                 sel_valid,
  output logic [LANE_W-1:0]                    sel_lane,
  output logic [AL_INDEX_WIDTH-1:0]            sel_ptr,
  output logic [ADDR_WIDTH-1:0]                sel_pc,
  output logic [REFETCH_WIDTH-1:0]             sel_refetch
);
  logic [AL_INDEX_WIDTH-1:0] best_age;
  logic [AL_INDEX_WIDTH-1:0] age;

  always_comb begin
    sel_valid   = 1'b0;
    sel_lane    = '0;
    sel_ptr     = '0;
    sel_pc      = '0;
    sel_refetch = '0;
    best_age    = '0;
    age         = '0;
    for (int i = 0; i < LANES; i++) begin
      age = ActiveListAge(ptr[i], head);
      // Strict less-than keeps the earlier (lower) lane on a tie.
      if (valid[i] && (!sel_valid || age < best_age)) begin
        sel_valid   = 1'b1;
        sel_lane    = LANE_W'(i);
        sel_ptr     = ptr[i];
        sel_pc      = pc[i];
        sel_refetch = refetch[i];
        best_age    = age;
      end
    end
  end
endmodule

// File: rtl/rw_recovery_request_arbiter.sv
// Keeps the oldest RW-stage recovery request (by ActiveList age), holds it
// while the recovery manager is busy, then issues it as a one-cycle strobe.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of rw_recovery_request_arbiter_if (lane requests,
//              head pointer, manager status in; issued request, pending out)
module rw_recovery_request_arbiter
  import rw_recovery_request_arbiter_pkg::*;
#(
  parameter int LANES          = 3,
  parameter int AL_INDEX_WIDTH = AL_INDEX_W,
  parameter int ADDR_WIDTH     = 32,
  parameter int REFETCH_WIDTH  = REFETCH_W,
  parameter int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input logic clk,
  input logic rst,
  rw_recovery_request_arbiter_if.slave bus
);
  RwRecoveryArbState state, state_nxt;

  logic [AL_INDEX_WIDTH-1:0] held_ptr;
  logic [ADDR_WIDTH-1:0]     held_pc;
  logic [REFETCH_WIDTH-1:0]  held_refetch;
  logic                      held_valid;

  logic                      new_valid;
  logic [LANE_W-1:0]         new_lane;
  logic [AL_INDEX_WIDTH-1:0] new_ptr;
  logic [ADDR_WIDTH-1:0]     new_pc;
  logic [REFETCH_WIDTH-1:0]  new_refetch;

  logic                      m_valid;
  logic                      m_lane;
  logic [AL_INDEX_WIDTH-1:0] m_ptr;
  logic [ADDR_WIDTH-1:0]     m_pc;
  logic [REFETCH_WIDTH-1:0]  m_refetch;

  logic load, clear;
  logic unused_lane;

  assign unused_lane = ^new_lane;
  assign held_valid  = (state != IDLE);

  rw_recovery_age_select #(
    .LANES(LANES), .AL_INDEX_WIDTH(AL_INDEX_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .REFETCH_WIDTH(REFETCH_WIDTH), .LANE_W(LANE_W)
  ) u_lane_sel (
    .valid(bus.req_valid), .ptr(bus.req_ptr), .pc(bus.req_pc),
    .refetch(bus.req_refetch), .head(bus.al_head_ptr),
    .sel_valid(new_valid), .sel_lane(new_lane), .sel_ptr(new_ptr),
    .sel_pc(new_pc), .sel_refetch(new_refetch)
  );

  // Held entry sits on slot 0, so a new request wins only if strictly older.
  rw_recovery_age_select #(
    .LANES(2), .AL_INDEX_WIDTH(AL_INDEX_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .REFETCH_WIDTH(REFETCH_WIDTH), .LANE_W(1)
  ) u_merge_sel (
    .valid({new_valid, held_valid}), .ptr({new_ptr, held_ptr}),
    .pc({new_pc, held_pc}), .refetch({new_refetch, held_refetch}),
    .head(bus.al_head_ptr),
    .sel_valid(m_valid), .sel_lane(m_lane), .sel_ptr(m_ptr),
    .sel_pc(m_pc), .sel_refetch(m_refetch)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (new_valid) begin
          state_nxt = HOLD;
          load      = 1'b1;
        end
      end
      HOLD: begin
        load = 1'b1;
        if (!bus.unable_to_start_recovery) state_nxt = ISSUE;
      end
      ISSUE: begin
        // Only arrivals older than the issued op survive its flush.
        if (m_valid && m_lane) begin
          state_nxt = HOLD;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.cm_exception_detected) begin
      state_nxt = IDLE;
      load      = 1'b0;
      clear     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      held_ptr                  <= '0;
      held_pc                   <= '0;
      held_refetch              <= REFETCH_WIDTH'(REFETCH_TYPE_THIS_PC);
      bus.exception_detected_rw <= 1'b0;
      bus.pending               <= 1'b0;
      bus.rw_exception_ptr      <= '0;
      bus.recovered_pc_rw       <= '0;
      bus.refetch_type_rw       <= REFETCH_WIDTH'(REFETCH_TYPE_THIS_PC);
    end else begin
      state <= state_nxt;
      if (clear) begin
        held_ptr     <= '0;
        held_pc      <= '0;
        held_refetch <= REFETCH_WIDTH'(REFETCH_TYPE_THIS_PC);
      end else if (load) begin
        held_ptr     <= m_ptr;
        held_pc      <= m_pc;
        held_refetch <= m_refetch;
      end
      bus.exception_detected_rw <= (state_nxt == ISSUE);
      bus.pending               <= (state_nxt != IDLE);
      if (state_nxt == ISSUE) begin
        bus.rw_exception_ptr <= m_ptr;
        bus.recovered_pc_rw  <= m_pc;
        bus.refetch_type_rw  <= m_refetch;
      end
    end
  end

  // CSR-target refetches never originate in the RW stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.req_valid[i]) begin
          assert (bus.req_refetch[i] != REFETCH_WIDTH'(REFETCH_TYPE_NEXT_PC_TO_CSR_TARGET) &&
                  bus.req_refetch[i] != REFETCH_WIDTH'(REFETCH_TYPE_THIS_PC_TO_CSR_TARGET));
        end
      end
    end
  end
endmodule
